// File: rtl/grid_mover.sv
// grid_mover: keycode-driven tile-grid actor with a one-cycle map lookup, sliding motion and a post-move cooldown.
// Define GRID_MOVER_WRAP_EN to wrap toroidally at the map edges instead of blocking there.
module grid_mover #(
   parameter int unsigned TILE_LOG2 = 5,
   parameter int unsigned MAP_W     = 20,
   parameter int unsigned MAP_H     = 15,
   parameter int unsigned STEP      = 2,
   parameter int unsigned START_TX  = 1,
   parameter int unsigned START_TY  = 13,
   parameter int unsigned COOLDOWN  = 4,
   parameter logic [7:0]  KEY_UP    = 8'h1A,
   parameter logic [7:0]  KEY_DOWN  = 8'h16,
   parameter logic [7:0]  KEY_LEFT  = 8'h04,
   parameter logic [7:0]  KEY_RIGHT = 8'h07
) (
   input  logic                            frame_clk,
   input  logic                            Reset,
   input  logic [7:0]                      keycode,
   output logic                            map_rd,
   output logic [$clog2(MAP_W*MAP_H)-1:0]  map_addr,
   input  logic                            map_wall,
   output logic [9:0]                      TankX,
   output logic [9:0]                      TankY,
   output logic [1:0]                      dir,
   output logic                            moving,
   output logic                            blocked
);

   localparam int unsigned AW  = $clog2(MAP_W * MAP_H);
   localparam int unsigned TXW = (MAP_W > 1) ? $clog2(MAP_W) : 1;
   localparam int unsigned TYW = (MAP_H > 1) ? $clog2(MAP_H) : 1;
   localparam int unsigned CW  = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;

   localparam logic [9:0]    STEP_PX  = 10'(STEP);
   localparam logic [9:0]    X_RST    = 10'(START_TX << TILE_LOG2);
   localparam logic [9:0]    Y_RST    = 10'(START_TY << TILE_LOG2);
   localparam logic [CW-1:0] CNT_LOAD = CW'(COOLDOWN);

`ifdef GRID_MOVER_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, LOOKUP, WAIT, SLIDE, COOL} state_t;

   state_t         state_q;
   logic [TXW-1:0] tx_q, tgt_tx_q, tgt_tx_d;
   logic [TYW-1:0] ty_q, tgt_ty_q, tgt_ty_d;
   logic           jump_q;
   logic [9:0]     x_q, y_q, x_d, y_d;
   logic [9:0]     tile_px, tile_py, tgt_px, tgt_py;
   logic [1:0]     dir_q, key_dir;
   logic           key_ok, edge_hit;
   logic           moving_q, blocked_q, rd_q;
   logic [AW-1:0]  addr_q, addr_d;
   logic [CW-1:0]  cnt_q;

   assign map_rd   = rd_q;
   assign map_addr = addr_q;
   assign TankX    = x_q;
   assign TankY    = y_q;
   assign dir      = dir_q;
   assign moving   = moving_q;
   assign blocked  = blocked_q;

   always_comb begin
      key_ok  = 1'b1;
      key_dir = 2'd0;
      if (keycode == KEY_UP)         key_dir = 2'd0;
      else if (keycode == KEY_RIGHT) key_dir = 2'd1;
      else if (keycode == KEY_DOWN)  key_dir = 2'd2;
      else if (keycode == KEY_LEFT)  key_dir = 2'd3;
      else                           key_ok  = 1'b0;
   end

   // Edge test is done on the current tile before stepping, so the neighbour never wraps by accident.
   always_comb begin
      tgt_tx_d = tx_q;
      tgt_ty_d = ty_q;
      edge_hit = 1'b0;
      case (key_dir)
         2'd0: if (ty_q == '0) begin
                  edge_hit = 1'b1;
                  tgt_ty_d = TYW'(MAP_H - 1);
               end else begin
                  tgt_ty_d = ty_q - TYW'(1);
               end
         2'd1: if (tx_q == TXW'(MAP_W - 1)) begin
                  edge_hit = 1'b1;
                  tgt_tx_d = '0;
               end else begin
                  tgt_tx_d = tx_q + TXW'(1);
               end
         2'd2: if (ty_q == TYW'(MAP_H - 1)) begin
                  edge_hit = 1'b1;
                  tgt_ty_d = '0;
               end else begin
                  tgt_ty_d = ty_q + TYW'(1);
               end
         default: if (tx_q == '0) begin
                  edge_hit = 1'b1;
                  tgt_tx_d = TXW'(MAP_W - 1);
               end else begin
                  tgt_tx_d = tx_q - TXW'(1);
               end
      endcase
      addr_d = AW'(32'(tgt_ty_d) * MAP_W + 32'(tgt_tx_d));
   end

   always_comb begin
      tile_px = 10'(32'(tx_q) << TILE_LOG2);
      tile_py = 10'(32'(ty_q) << TILE_LOG2);
      tgt_px  = 10'(32'(tgt_tx_q) << TILE_LOG2);
      tgt_py  = 10'(32'(tgt_ty_q) << TILE_LOG2);
      x_d = x_q;
      y_d = y_q;
      if (x_q < tile_px)      x_d = x_q + STEP_PX;
      else if (x_q > tile_px) x_d = x_q - STEP_PX;
      if (y_q < tile_py)      y_d = y_q + STEP_PX;
      else if (y_q > tile_py) y_d = y_q - STEP_PX;
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= IDLE;
         tx_q      <= TXW'(START_TX);
         ty_q      <= TYW'(START_TY);
         tgt_tx_q  <= TXW'(START_TX);
         tgt_ty_q  <= TYW'(START_TY);
         jump_q    <= 1'b0;
         x_q       <= X_RST;
         y_q       <= Y_RST;
         dir_q     <= 2'd0;
         moving_q  <= 1'b0;
         blocked_q <= 1'b0;
         rd_q      <= 1'b0;
         addr_q    <= '0;
         cnt_q     <= '0;
      end else begin
         blocked_q <= 1'b0;
         case (state_q)
            IDLE: if (key_ok) begin
               dir_q <= key_dir;
               if (edge_hit && !WRAP_EN) begin
                  blocked_q <= 1'b1;
                  cnt_q     <= CNT_LOAD;
                  state_q   <= COOL;
               end else begin
                  tgt_tx_q <= tgt_tx_d;
                  tgt_ty_q <= tgt_ty_d;
                  jump_q   <= edge_hit;
                  rd_q     <= 1'b1;
                  addr_q   <= addr_d;
                  state_q  <= LOOKUP;
               end
            end
            LOOKUP: begin
               rd_q    <= 1'b0;
               state_q <= WAIT;
            end
            WAIT: if (map_wall) begin
               blocked_q <= 1'b1;
               cnt_q     <= CNT_LOAD;
               state_q   <= COOL;
            end else begin
               tx_q <= tgt_tx_q;
               ty_q <= tgt_ty_q;
               if (jump_q) begin
                  // Wrapped moves teleport rather than slide across the whole map.
                  x_q     <= tgt_px;
                  y_q     <= tgt_py;
                  cnt_q   <= CNT_LOAD;
                  state_q <= COOL;
               end else begin
                  moving_q <= 1'b1;
                  state_q  <= SLIDE;
               end
            end
            SLIDE: begin
               x_q <= x_d;
               y_q <= y_d;
               if (x_d == tile_px && y_d == tile_py) begin
                  moving_q <= 1'b0;
                  cnt_q    <= CNT_LOAD;
                  state_q  <= COOL;
               end
            end
            COOL: if (cnt_q <= CW'(1)) begin
               cnt_q   <= '0;
               state_q <= IDLE;
            end else begin
               cnt_q <= cnt_q - CW'(1);
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_grid_mover.sv
// tb_grid_mover: directed move table, reset corner cases and random moves checked against a per-move arithmetic model.
module tb_grid_mover;

   localparam int TILE_LOG2 = 5;
   localparam int MAP_W     = 20;
   localparam int MAP_H     = 15;
   localparam int STEP      = 2;
   localparam int START_TX  = 1;
   localparam int START_TY  = 13;
   localparam int COOLDOWN  = 4;
   localparam int TILE      = 1 << TILE_LOG2;
   localparam int NSTEP     = TILE / STEP;
   localparam int NT        = MAP_W * MAP_H;
   localparam int AW        = $clog2(NT);
   localparam logic [7:0] KU = 8'h1A, KD = 8'h16, KL = 8'h04, KR = 8'h07;

`ifdef GRID_MOVER_WRAP_EN
   localparam bit WR = 1'b1;
`else
   localparam bit WR = 1'b0;
`endif

   localparam int K_NONE = 0, K_EDGE = 1, K_WALL = 2, K_JUMP = 3, K_SLIDE = 4;

   logic          frame_clk, Reset, map_rd, map_wall, moving, blocked;
   logic [7:0]    keycode;
   logic [AW-1:0] map_addr;
   logic [9:0]    TankX, TankY;
   logic [1:0]    dir;

   grid_mover #(
      .TILE_LOG2(TILE_LOG2), .MAP_W(MAP_W), .MAP_H(MAP_H), .STEP(STEP),
      .START_TX(START_TX), .START_TY(START_TY), .COOLDOWN(COOLDOWN),
      .KEY_UP(KU), .KEY_DOWN(KD), .KEY_LEFT(KL), .KEY_RIGHT(KR)
   ) dut (
      .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
      .map_rd(map_rd), .map_addr(map_addr), .map_wall(map_wall),
      .TankX(TankX), .TankY(TankY), .dir(dir), .moving(moving), .blocked(blocked)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   bit wall_mem [0:NT-1];
   int checks = 0, errors = 0;
   int mtx, mty, mdir;
   int rd_cnt, rd_addr, blk_cnt;

   // Map store: answer is valid only in the cycle after map_rd, inverted garbage otherwise.
   initial begin
      bit pend = 1'b0;
      bit wv   = 1'b0;
      forever begin
         @(negedge frame_clk);
         map_wall = pend ? wv : ~wv;
         pend     = map_rd;
         wv       = wall_mem[map_addr];
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: actual %0d required %0d", name, $time, act, exp);
      end
   endtask

   function automatic int decode_key(input logic [7:0] k);
      if (k == KU) return 0;
      if (k == KR) return 1;
      if (k == KD) return 2;
      if (k == KL) return 3;
      return -1;
   endfunction

   task automatic model_reset();
      mtx = START_TX; mty = START_TY; mdir = 0;
   endtask

   // Drives one key at the next edge and checks every frame of the resulting move.
   task automatic run_txn(input logic [7:0] key, input bit hold);
      int d, ntx, nty, kind, p, sx, sy, ex, ey, sgx, sgy, addr, cc, k, cx, cy;
      int ex_rd, ex_blk, ex_mov;
      bit oob;
      d = decode_key(key);
      ntx = mtx; nty = mty; addr = -1; kind = K_NONE;
      cc = (COOLDOWN == 0) ? 1 : COOLDOWN;
      if (d >= 0) begin
         ntx = mtx + ((d == 1) ? 1 : 0) - ((d == 3) ? 1 : 0);
         nty = mty + ((d == 2) ? 1 : 0) - ((d == 0) ? 1 : 0);
         oob = (ntx < 0) || (ntx >= MAP_W) || (nty < 0) || (nty >= MAP_H);
         if (oob && !WR) kind = K_EDGE;
         else begin
            ntx  = (ntx + MAP_W) % MAP_W;
            nty  = (nty + MAP_H) % MAP_H;
            addr = nty * MAP_W + ntx;
            if (wall_mem[addr]) kind = K_WALL;
            else if (oob)       kind = K_JUMP;
            else                kind = K_SLIDE;
         end
      end
      case (kind)
         K_NONE:  p = 1;
         K_EDGE:  p = 1 + cc;
         K_SLIDE: p = 3 + NSTEP + cc;
         default: p = 3 + cc;
      endcase
      sx = mtx * TILE; sy = mty * TILE;
      ex = ntx * TILE; ey = nty * TILE;
      sgx = (ex > sx) ? 1 : ((ex < sx) ? -1 : 0);
      sgy = (ey > sy) ? 1 : ((ey < sy) ? -1 : 0);
      rd_cnt = 0; blk_cnt = 0; rd_addr = -1;
      keycode = key;
      for (int j = 0; j < p; j++) begin
         @(negedge frame_clk);
         ex_rd  = (j == 0 && addr >= 0) ? 1 : 0;
         ex_blk = ((kind == K_EDGE && j == 0) || (kind == K_WALL && j == 2)) ? 1 : 0;
         ex_mov = (kind == K_SLIDE && j >= 2 && j <= NSTEP + 1) ? 1 : 0;
         cx = sx; cy = sy;
         if (kind == K_SLIDE) begin
            k  = (j < 2) ? 0 : ((j - 2 > NSTEP) ? NSTEP : j - 2);
            cx = sx + sgx * STEP * k;
            cy = sy + sgy * STEP * k;
         end else if (kind == K_JUMP && j >= 2) begin
            cx = ex; cy = ey;
         end
         chk("map_rd", map_rd, ex_rd);
         if (ex_rd == 1) chk("map_addr", map_addr, addr);
         chk("blocked", blocked, ex_blk);
         chk("moving", moving, ex_mov);
         chk("TankX", TankX, cx);
         chk("TankY", TankY, cy);
         chk("dir", dir, (d >= 0) ? d : mdir);
         if (map_rd) begin rd_cnt++; rd_addr = map_addr; end
         if (blocked) blk_cnt++;
         keycode = (j <= p - 2) ? (hold ? key : 8'($urandom)) : 8'h00;
      end
      if (kind == K_SLIDE || kind == K_JUMP) begin mtx = ntx; mty = nty; end
      if (d >= 0) mdir = d;
   endtask

   typedef struct {
      logic [7:0] key;
      bit         wall;
      int         addr;
      int         x;
      int         y;
      int         d;
      int         blk;
   } vec_t;

   vec_t vec [10];

   initial begin
      int ex19;
      ex19 = WR ? 608 : 0;
      vec[0] = '{KU, 1'b1, 241, 32, 416, 0, 1};
      vec[1] = '{KR, 1'b0, 262, 64, 416, 1, 0};
      vec[2] = '{KU, 1'b1, 242, 64, 416, 0, 1};
      vec[3] = '{KL, 1'b0, 261, 32, 416, 3, 0};
      vec[4] = '{KL, 1'b0, 260, 0, 416, 3, 0};
      vec[5] = '{KL, 1'b0, WR ? 279 : -1, ex19, 416, 3, WR ? 0 : 1};
      vec[6] = '{KD, 1'b0, WR ? 299 : 280, ex19, 448, 2, 0};
      vec[7] = '{KD, 1'b1, WR ? 19 : -1, ex19, 448, 2, 1};
      vec[8] = '{8'h55, 1'b0, -1, ex19, 448, 2, 0};
      vec[9] = '{KU, 1'b0, WR ? 279 : 260, ex19, 416, 0, 0};

      for (int i = 0; i < NT; i++) wall_mem[i] = 1'b0;
      Reset = 1'b1; keycode = 8'h00; map_wall = 1'b0;
      repeat (3) @(negedge frame_clk);
      chk("rst_TankX", TankX, 32);
      chk("rst_TankY", TankY, 416);
      chk("rst_dir", dir, 0);
      chk("rst_moving", moving, 0);
      chk("rst_map_rd", map_rd, 0);
      chk("rst_blocked", blocked, 0);
      chk("rst_map_addr", map_addr, 0);
      Reset = 1'b0;
      model_reset();

      for (int i = 0; i < 10; i++) begin
         if (vec[i].addr >= 0) wall_mem[vec[i].addr] = vec[i].wall;
         run_txn(vec[i].key, 1'b0);
         chk("vec_TankX", TankX, vec[i].x);
         chk("vec_TankY", TankY, vec[i].y);
         chk("vec_dir", dir, vec[i].d);
         chk("vec_rd_count", rd_cnt, (vec[i].addr >= 0) ? 1 : 0);
         if (vec[i].addr >= 0) chk("vec_addr", rd_addr, vec[i].addr);
         chk("vec_blocked_count", blk_cnt, vec[i].blk);
      end

      // Reset in the middle of a slide.
      Reset = 1'b1;
      @(negedge frame_clk);
      Reset = 1'b0;
      model_reset();
      wall_mem[262] = 1'b0;
      keycode = KR;
      @(negedge frame_clk);
      keycode = 8'h00;
      repeat (10) @(negedge frame_clk);
      chk("slide_frame8_TankX", TankX, 48);
      chk("slide_frame8_moving", moving, 1);
      #2 Reset = 1'b1;
      #1;
      chk("async_rst_TankX", TankX, 32);
      chk("async_rst_TankY", TankY, 416);
      chk("async_rst_moving", moving, 0);
      chk("async_rst_dir", dir, 0);
      @(negedge frame_clk);
      Reset = 1'b0;
      model_reset();

      // Reset during the lookup: the wall answer arriving under reset must be forgotten.
      wall_mem[262] = 1'b1;
      keycode = KR;
      @(negedge frame_clk);
      chk("lookup_map_rd", map_rd, 1);
      chk("lookup_map_addr", map_addr, 262);
      keycode = 8'h00;
      @(negedge frame_clk);
      #2 Reset = 1'b1;
      @(negedge frame_clk);
      chk("lookup_rst_blocked", blocked, 0);
      chk("lookup_rst_map_rd", map_rd, 0);
      chk("lookup_rst_TankX", TankX, 32);
      Reset = 1'b0;
      model_reset();
      wall_mem[262] = 1'b0;
      run_txn(KR, 1'b0);
      chk("post_rst_TankX", TankX, 64);

      for (int i = 0; i < NT; i++) wall_mem[i] = ($urandom_range(0, 3) == 0);
      for (int n = 0; n < 120; n++) begin
         logic [7:0] key;
         bit         hold;
         int         r;
         r = $urandom_range(0, 9);
         case (r % 5)
            0: key = KU;
            1: key = KR;
            2: key = KD;
            3: key = KL;
            default: key = 8'($urandom);
         endcase
         hold = ($urandom_range(0, 1) == 1);
         run_txn(key, hold);
         if (hold) run_txn(key, 1'b1);
      end

      keycode = 8'h00;
      repeat (2) @(negedge frame_clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
